// File: rtl/scan_decoder.sv
// scan_decoder: one-hot select decoder with a prescaled scanning mode.
//
// With en low the block idles: the output is dark and the index is held.
// In DECODE the index is loaded from d on a load strobe. In SCAN the index
// steps once every period+1 cycles and wraps modulo 2**SEL_W. The wrap
// output pulses for the cycle in which the wrapped index first appears.
//
// Optional feature macro: SCAN_DIR_EN. When it is defined, the dir port
// exists and selects the step direction (0 = up, 1 = down). When it is not
// defined, scanning always counts up.
module scan_decoder #(
  parameter int SEL_W = 4,
  parameter int DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      d,
  input  logic [DIV_W-1:0]      period,
`ifdef SCAN_DIR_EN
  input  logic                  dir,
`endif
  output logic [(2**SEL_W)-1:0] q,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [DIV_W-1:0] cnt;
  logic [SEL_W-1:0] step_idx;
  logic             step_wrap;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] v);
    logic [OUT_W-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  // Target state follows en/mode directly. The scan step candidate is the
  // neighbouring index, along with a flag that says whether it wraps.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so that no path through the block leaves a latch.
    nxt_state = ST_IDLE;
    if (en) nxt_state = mode ? ST_SCAN : ST_DECODE;

    step_idx  = idx + 1'b1;
    step_wrap = (idx == '1);
`ifdef SCAN_DIR_EN
    if (dir) begin
      step_idx  = idx - 1'b1;
      step_wrap = (idx == '0);
    end
`endif
  end

  // FSM with registered outputs. Outputs are computed for the state that is
  // being entered, so q always matches the index visible in the same cycle.
  // A change of state never carries a partial prescaler count across.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' only, so every register
    // sees pre-edge values regardless of statement order.
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      q     <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= nxt_state;
      wrap  <= 1'b0;
      cnt   <= '0;
      case (nxt_state)
        ST_IDLE: begin
          q <= '0;
        end
        ST_DECODE: begin
          if (load) begin
            idx <= d;
            q   <= onehot(d);
          end else begin
            q <= onehot(idx);
          end
        end
        ST_SCAN: begin
          if (load) begin
            // A load takes priority over a step that falls due in the same cycle.
            idx <= d;
            q   <= onehot(d);
          end else if (state == ST_SCAN && cnt >= period) begin
            // Using >= means that lowering period below cnt steps at once.
            idx  <= step_idx;
            q    <= onehot(step_idx);
            wrap <= step_wrap;
          end else begin
            q <= onehot(idx);
            if (state == ST_SCAN) cnt <= cnt + 1'b1;
          end
        end
        default: begin
          q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder (SEL_W=4, DIV_W=8). It runs directed
// scenarios and then random traffic. All of it is checked against an
// integer reference model of the block's behaviour.
module tb_scan_decoder;

  localparam int SEL_W = 4;
  localparam int DIV_W = 8;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             mode;
  logic             load;
  logic [SEL_W-1:0] d;
  logic [DIV_W-1:0] period;
  logic             dir;
  logic [OUT_W-1:0] q;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state. m_mode: 0 = idle, 1 = decode, 2 = scan.
  int m_mode = 0;
  int m_idx  = 0;
  int m_cnt  = 0;
  bit m_wrap = 1'b0;

  scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .load   (load),
    .d      (d),
    .period (period),
`ifdef SCAN_DIR_EN
    .dir    (dir),
`endif
    .q      (q),
    .idx    (idx),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  // Apply the behavioural rules to the inputs seen at one rising edge.
  task automatic model_edge();
    int  tgt;
    bit  down;
    if (reset) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_wrap = 1'b0;
      return;
    end
`ifdef SCAN_DIR_EN
    down = dir;
`else
    down = 1'b0;
`endif
    tgt    = !en ? 0 : (mode ? 2 : 1);
    m_wrap = 1'b0;
    if (tgt != 2 || m_mode != 2) begin
      m_cnt = 0;
      if (tgt != 0 && load) m_idx = int'(d);
    end else if (load) begin
      m_idx = int'(d);
      m_cnt = 0;
    end else if (m_cnt >= int'(period)) begin
      m_cnt = 0;
      if (down) begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + OUT_W - 1) % OUT_W;
      end else begin
        m_wrap = (m_idx == OUT_W - 1);
        m_idx  = (m_idx + 1) % OUT_W;
      end
    end else begin
      m_cnt++;
    end
    m_mode = tgt;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [OUT_W-1:0] exp_q;
    exp_q = (m_mode == 0) ? '0 : OUT_W'(1) << m_idx;
    check_val({tag, ".q"},    32'(q),    32'(exp_q));
    check_val({tag, ".idx"},  32'(idx),  32'(m_idx));
    check_val({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  // Apply inputs, then wait one rising edge and advance the model. Outputs
  // are compared 1 ns after that edge.
  task automatic cyc(input logic r, input logic e, input logic m, input logic l,
                     input logic [SEL_W-1:0] dv, input logic [DIV_W-1:0] p, input string tag);
    reset = r; en = e; mode = m; load = l; d = dv; period = p;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; d = '0; period = '0; dir = 1'b0;

    // Reset state.
    cyc(1, 0, 0, 0, 4'h0, 8'd0, "reset0");
    cyc(1, 1, 1, 1, 4'h9, 8'd0, "reset1");
    check_val("reset.q", 32'(q), 32'h0);
    check_val("reset.idx", 32'(idx), 32'd0);

    // Decode: a load takes effect one cycle later and then holds.
    cyc(0, 1, 0, 1, 4'hA, 8'd0, "dec_load");
    check_val("dec_load.q_const", 32'(q), 32'h0000_0400);
    check_val("dec_load.idx_const", 32'(idx), 32'd10);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 4'h3, 8'd0, "dec_hold");
    check_val("dec_hold.q_const", 32'(q), 32'h0000_0400);

    // Load is ignored while idle. Re-entering decode shows the retained index.
    cyc(0, 0, 0, 1, 4'h5, 8'd0, "idle_load");
    check_val("idle.q_const", 32'(q), 32'h0);
    cyc(0, 1, 0, 0, 4'h5, 8'd0, "dec_reenter");
    check_val("dec_reenter.q_const", 32'(q), 32'h0000_0400);

    // Scan with period=2, starting from idx=14, including the up-wrap.
    cyc(0, 1, 0, 1, 4'hE, 8'd2, "pre_scan_load");
    cyc(0, 1, 1, 0, 4'h0, 8'd2, "scan_enter");
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 1, 1, 0, 4'h0, 8'd2, "scan_p2");
      if (i == 3) check_val("scan_p2.idx15", 32'(idx), 32'd15);
      if (i == 6) begin
        check_val("scan_p2.idx0", 32'(idx), 32'd0);
        check_val("scan_p2.wrap1", 32'(wrap), 32'd1);
        check_val("scan_p2.q1", 32'(q), 32'h0000_0001);
      end
      if (i == 7) check_val("scan_p2.wrap_drop", 32'(wrap), 32'd0);
    end

    // Period 0 steps every cycle. A load coincident with a step wins.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 4'h0, 8'd0, "scan_p0");
    cyc(0, 1, 1, 1, 4'h3, 8'd0, "scan_load_beats_step");
    check_val("load_step.idx3", 32'(idx), 32'd3);
    check_val("load_step.nowrap", 32'(wrap), 32'd0);
    cyc(0, 1, 1, 0, 4'h0, 8'd0, "scan_after_load");
    check_val("after_load.idx4", 32'(idx), 32'd4);

    // Lowering period below the running count forces a step on the next cycle.
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 4'h0, 8'd9, "scan_p9");
    cyc(0, 1, 1, 0, 4'h0, 8'd1, "scan_lowered");

`ifdef SCAN_DIR_EN
    // Down direction: 0 steps to 15 and raises wrap.
    cyc(0, 1, 1, 1, 4'h0, 8'd0, "dir_load0");
    dir = 1'b1;
    cyc(0, 1, 1, 0, 4'h0, 8'd0, "dir_down_wrap");
    check_val("dir_down.idx15", 32'(idx), 32'd15);
    check_val("dir_down.q", 32'(q), 32'h0000_8000);
    check_val("dir_down.wrap", 32'(wrap), 32'd1);
    dir = 1'b0;
`endif

    // Disable mid-scan, then re-enable. The count restarts from zero.
    cyc(0, 1, 1, 1, 4'h6, 8'd1, "mid_load6");
    cyc(0, 0, 1, 0, 4'h0, 8'd1, "mid_disable");
    check_val("mid_disable.q0", 32'(q), 32'h0);
    cyc(0, 1, 1, 0, 4'h0, 8'd1, "mid_reenable");
    check_val("mid_reenable.q", 32'(q), 32'h0000_0040);
    cyc(0, 1, 1, 0, 4'h0, 8'd1, "mid_cnt1");
    check_val("mid_cnt1.idx6", 32'(idx), 32'd6);
    cyc(0, 1, 1, 0, 4'h0, 8'd1, "mid_step");
    check_val("mid_step.idx7", 32'(idx), 32'd7);

    // A mode toggle clears the count while keeping the index.
    cyc(0, 1, 0, 0, 4'h0, 8'd1, "toggle_dec");
    cyc(0, 1, 1, 0, 4'h0, 8'd1, "toggle_scan");
    cyc(0, 1, 1, 0, 4'h0, 8'd1, "toggle_cnt");

    // Reset arriving together with a load during scan discards the capture.
    cyc(1, 1, 1, 1, 4'h7, 8'd0, "reset_vs_load");
    check_val("reset_load.q", 32'(q), 32'h0);
    check_val("reset_load.idx", 32'(idx), 32'd0);
    check_val("reset_load.wrap", 32'(wrap), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic r, e, m, l;
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 9) != 0);
      m = ($urandom_range(0, 7) != 0);
      l = ($urandom_range(0, 5) == 0);
      dir = 1'($urandom_range(0, 1));
      cyc(r, e, m, l, 4'($urandom), 8'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
